pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the five-stage ARM pipeline: IF, IF_reg, ID, EXE and MEM registers.
- Detects read-after-write data hazards between the instruction in ID and the in-flight instructions in EXE and MEM.
- Handles taken-branch flushes.
- Holds the whole pipeline while a multi-cycle data-memory access completes.
- Drives the freeze/flush inputs of IF_Stage and IF_reg, plus the bubble and hold controls of the downstream pipeline registers, replacing the constant tie-offs used so far.

---
 rtl/arm_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared pipeline sequencing types and constants
package arm_pkg;

    localparam int REG_ADDR_W_DEF = 4;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } ctrl_state_e;

    // mov r0, r0 - loaded by IF_reg on flush_if and by ID/EXE on bubble_ex
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard/flush/memory-hold sequencer for the ARM pipeline
// FORWARDING_EN: when defined, only load-use hazards against EXE stall ID.
module pipeline_hazard_ctrl
    import arm_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  freeze_if,
    output logic                  flush_if,
    output logic                  bubble_ex,
    output logic                  hold_all,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(MEM_TIMEOUT);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic             r_timeout;
    logic             w_hazard;
    logic             w_freeze, w_flush, w_bubble, w_hold;
    logic             w_stall_inc, w_flush_inc, w_wait_inc, w_wait_clr;
    logic [CNT_W-1:0] w_wait_cnt;
    logic [CNT_W:0]   w_wait_next;
    logic             w_exe_hit;

    assign w_exe_hit = exe_wb_en & ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));

`ifdef FORWARDING_EN
    assign w_hazard = id_valid & exe_mem_read & w_exe_hit;
`else
    logic w_mem_hit;
    logic w_unused_mem_read;
    assign w_unused_mem_read = exe_mem_read;
    assign w_mem_hit = mem_wb_en & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
    assign w_hazard  = id_valid & (w_exe_hit | w_mem_hit);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_hold      = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    w_hold      = 1'b1;
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    w_flush     = 1'b1;
                    w_bubble    = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_hazard) begin
                    w_freeze    = 1'b1;
                    w_bubble    = 1'b1;
                    w_stall_inc = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // EXE is frozen too, so a pending branch is acted on after the access
                w_hold   = 1'b1;
                w_freeze = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_wait_inc  = (r_state == ST_MEM_WAIT);
    assign w_wait_clr  = (r_state == ST_MEM_WAIT) & mem_ready;
    assign w_wait_next = {1'b0, w_wait_cnt} + 1'b1;

    // Flag rises on the edge that ends the MEM_TIMEOUT-th waiting cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_wait_inc && (w_wait_next >= TIMEOUT_LIM)) begin
            r_timeout <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk(clk), .i_rst_n(rst), .i_inc(w_stall_inc), .i_clr(1'b0), .o_cnt(stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk(clk), .i_rst_n(rst), .i_inc(w_flush_inc), .i_clr(1'b0), .o_cnt(flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .i_clk(clk), .i_rst_n(rst), .i_inc(w_wait_inc), .i_clr(w_wait_clr), .o_cnt(w_wait_cnt)
    );

    // Gate with reset so the controls drop at once, even while mem_req is high
    assign freeze_if   = w_freeze & rst;
    assign flush_if    = w_flush  & rst;
    assign bubble_ex   = w_bubble & rst;
    assign hold_all    = w_hold   & rst;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench with a cycle-level reference model
module tb_pipeline_hazard_ctrl;

    localparam int RW  = 4;
    localparam int CW  = 4;
    localparam int TMO = 8;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic          id_valid;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic          two;
        logic          exe_wb;
        logic [RW-1:0] exe_dest;
        logic          exe_mr;
        logic          mem_wb;
        logic [RW-1:0] mem_dest;
        logic          br;
        logic          mreq;
        logic          mrdy;
    } stim_t;

    typedef struct {
        bit freeze, flush, bubble, hold, tmo;
        int stall, flushes;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 0, id_two_src = 0, exe_wb_en = 0, exe_mem_read = 0, mem_wb_en = 0;
    logic branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic [RW-1:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic freeze_if, flush_if, bubble_ex, hold_all, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(freeze_if), .flush_if(flush_if), .bubble_ex(bubble_ex), .hold_all(hold_all),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_exp[$];

    bit m_wait;
    int m_wcycles, m_stall, m_flush;
    bit m_tmo;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit model_hazard(input stim_t s);
        bit e1, e2;
        e1 = s.exe_wb && (s.exe_dest == s.src1);
        e2 = s.two && s.exe_wb && (s.exe_dest == s.src2);
`ifdef FORWARDING_EN
        return s.id_valid && s.exe_mr && (e1 || e2);
`else
        return s.id_valid && (e1 || e2 ||
               (s.mem_wb && s.mem_dest == s.src1) ||
               (s.two && s.mem_wb && s.mem_dest == s.src2));
`endif
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.id_valid; id_src1 = s.src1; id_src2 = s.src2; id_two_src = s.two;
        exe_wb_en = s.exe_wb; exe_dest = s.exe_dest; exe_mem_read = s.exe_mr;
        mem_wb_en = s.mem_wb; mem_dest = s.mem_dest;
        branch_taken = s.br; mem_req = s.mreq; mem_ready = s.mrdy;
    endtask

    // One clock of stimulus; the model predicts this cycle's outputs, then advances.
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e = '{freeze: 0, flush: 0, bubble: 0, hold: 0, tmo: m_tmo, stall: m_stall, flushes: m_flush};
        if (m_wait) begin
            e.hold = 1; e.freeze = 1;
            m_wcycles++;
            if (m_wcycles >= TMO) m_tmo = 1;
            if (s.mrdy) begin
                m_wait = 0; m_wcycles = 0;
            end
        end else if (s.mreq && !s.mrdy) begin
            e.hold = 1; e.freeze = 1;
            m_wait = 1;
        end else if (s.br) begin
            e.flush = 1; e.bubble = 1;
            m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        end else if (model_hazard(s)) begin
            e.freeze = 1; e.bubble = 1;
            m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        end
        q_exp.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_freeze_if", freeze_if, 0);
        chk("rst_flush_if", flush_if, 0);
        chk("rst_bubble_ex", bubble_ex, 0);
        chk("rst_hold_all", hold_all, 0);
        chk("rst_mem_timeout", mem_timeout, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        apply('0);
        m_wait = 0; m_wcycles = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("freeze_if", freeze_if, e.freeze);
                chk("flush_if", flush_if, e.flush);
                chk("bubble_ex", bubble_ex, e.bubble);
                chk("hold_all", hold_all, e.hold);
                chk("mem_timeout", mem_timeout, e.tmo);
                chk("stall_cnt", stall_cnt, e.stall);
                chk("flush_cnt", flush_cnt, e.flushes);
            end
        end
    end

    initial begin : driver
        stim_t s;
        do_reset();
        step('0);

        // RAW on src1 against EXE (no stall under forwarding since it is not a load)
        s = '0; s.id_valid = 1; s.src1 = 3; s.src2 = 9; s.exe_wb = 1; s.exe_dest = 3;
        step(s);
        step('0);
        // Branch squashes an ID instruction that also has a MEM-stage hazard on src2
        s = '0; s.id_valid = 1; s.src1 = 1; s.src2 = 5; s.two = 1; s.mem_wb = 1; s.mem_dest = 5; s.br = 1;
        step(s);
        step('0);
        // Four-cycle memory access with a branch pending inside the wait
        s = '0; s.mreq = 1;
        step(s);
        s.br = 1;
        repeat (3) step(s);
        s.mrdy = 1;
        step(s);
        s.mreq = 0; s.mrdy = 0;
        step(s);
        step('0);
        // Same-cycle request and completion: no stall
        s = '0; s.mreq = 1; s.mrdy = 1;
        step(s);
        step('0);

        // Counter saturation
        do_reset();
        s = '0; s.id_valid = 1; s.src1 = 3; s.exe_wb = 1; s.exe_dest = 3; s.exe_mr = 1;
        repeat ((1 << CW) + 3) step(s);
        step('0);

        // Watchdog: stays set after the access completes
        do_reset();
        s = '0; s.mreq = 1;
        step(s);
        repeat (12) step(s);
        s.mrdy = 1;
        step(s);
        repeat (2) step('0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 500; i++) begin
            s.id_valid = 1'($urandom_range(0, 1));
            s.src1     = 4'($urandom_range(0, 3));
            s.src2     = 4'($urandom_range(0, 3));
            s.two      = 1'($urandom_range(0, 1));
            s.exe_wb   = 1'($urandom_range(0, 1));
            s.exe_dest = 4'($urandom_range(0, 3));
            s.exe_mr   = 1'($urandom_range(0, 1));
            s.mem_wb   = 1'($urandom_range(0, 1));
            s.mem_dest = 4'($urandom_range(0, 3));
            s.br       = ($urandom_range(0, 5) == 0);
            s.mreq     = ($urandom_range(0, 7) == 0);
            s.mrdy     = 1'($urandom_range(0, 1));
            step(s);
        end

        // Asynchronous reset in the middle of a memory wait
        s = '0; s.mreq = 1;
        repeat (3) step(s);
        do_reset();
        step('0);
        s = '0; s.id_valid = 1; s.src1 = 2; s.exe_wb = 1; s.exe_dest = 2; s.exe_mr = 1;
        step(s);
        step('0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
